// File: rtl/rtc_alarm_core.sv
`timescale 1ns/1ps
// rtc_alarm_core
// Timekeeping core: 24-hour counters advanced by a prescaled 1 Hz tick,
// N_ALARMS programmable alarm slots with snooze and auto-timeout, an hourly
// chime and a 12/24-hour display view of the hour.
//
// Ports
//   clk, clr            system clock, asynchronous active-high reset
//   mode_12h            selects 12-hour view on disp_hour/pm
//   alarm_en            per-slot arm mask
//   wr_en/wr_target/    single-cycle write strobe; target 0 = time,
//   wr_field/wr_value     k = alarm slot k-1; field 0/1/2 = h/m/s
//   snooze, dismiss     single-cycle control pulses for a ringing alarm
//   hour/minute/second  current time in binary
//   disp_hour, pm       hour in the selected view
//   sec_pulse           one-cycle strobe per second advance
//   chime               hourly chime active
//   ringing, snoozed    alarm ring / snooze interval active
//   ring_id             slot that caused the current ring/snooze
//   wr_err              one-cycle strobe after a rejected write
module rtc_alarm_core #(
  parameter int CLK_HZ     = 100000000,
  parameter int N_ALARMS   = 4,
  parameter int CHIME_SECS = 3,
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                mode_12h,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                wr_en,
  input  logic [2:0]          wr_target,
  input  logic [1:0]          wr_field,
  input  logic [5:0]          wr_value,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [4:0]          hour,
  output logic [5:0]          minute,
  output logic [5:0]          second,
  output logic [4:0]          disp_hour,
  output logic                pm,
  output logic                sec_pulse,
  output logic                chime,
  output logic                ringing,
  output logic [2:0]          ring_id,
  output logic                snoozed,
  output logic                wr_err
);

  localparam int              PW          = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [9:0]      RING_LOAD   = 10'(RING_SECS);
  localparam logic [9:0]      SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
  localparam logic [3:0]      CHIME_LOAD  = 4'(CHIME_SECS);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  logic [PW-1:0]               presc_q, presc_d;
  logic [4:0]                  hour_q, hour_d;
  logic [5:0]                  min_q, min_d, sec_q, sec_d;
  logic [N_ALARMS-1:0][4:0]    alm_hour_q, alm_hour_d;
  logic [N_ALARMS-1:0][5:0]    alm_min_q, alm_min_d, alm_sec_q, alm_sec_d;
  logic [3:0]                  chime_cnt_q, chime_cnt_d;
  logic [9:0]                  alm_cnt_q, alm_cnt_d;
  state_t                      state_q, state_d;
  logic [2:0]                  ring_id_q, ring_id_d;
  logic                        sec_pulse_q, wr_err_q;

  logic       tick, adv, wr_ok, time_wr, range_ok;
  logic       match_any, en_sel;
  logic [2:0] match_idx;

  // Write validation; a time write steals the tick of the same cycle,
  // so "adv" is the tick that actually moves the clock forward.
  always_comb begin
    range_ok = 1'b0;
    case (wr_field)
      2'd0:    range_ok = (wr_value <= 6'd23);
      2'd1,
      2'd2:    range_ok = (wr_value <= 6'd59);
      default: range_ok = 1'b0;
    endcase
    wr_ok   = wr_en && (wr_target <= 3'(N_ALARMS)) && range_ok;
    time_wr = wr_ok && (wr_target == 3'd0);
    tick    = (presc_q == PRESC_MAX);
    adv     = tick && !time_wr;
  end

  // Prescaler and time counters; all carries ripple within one tick.
  always_comb begin
    presc_d = (tick || (time_wr && wr_field == 2'd2)) ? '0 : presc_q + 1'b1;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (time_wr) begin
      case (wr_field)
        2'd0:    hour_d = wr_value[4:0];
        2'd1:    min_d  = wr_value;
        default: sec_d  = wr_value;
      endcase
    end else if (adv) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Alarm slot storage, then match against the post-tick time. Scanning
  // from the top slot down leaves the lowest matching index in match_idx.
  always_comb begin
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    alm_sec_d  = alm_sec_q;
    match_any  = 1'b0;
    match_idx  = 3'd0;
    en_sel     = 1'b0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (wr_ok && wr_target == 3'(i + 1)) begin
        case (wr_field)
          2'd0:    alm_hour_d[i] = wr_value[4:0];
          2'd1:    alm_min_d[i]  = wr_value;
          default: alm_sec_d[i]  = wr_value;
        endcase
      end
      if (ring_id_q == 3'(i)) en_sel = alarm_en[i];
    end
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && alm_hour_q[i] == hour_d &&
          alm_min_q[i] == min_d && alm_sec_q[i] == sec_d) begin
        match_any = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  // Hourly chime: loaded when a tick lands on mm:ss = 00:00.
  always_comb begin
    chime_cnt_d = chime_cnt_q;
    if (adv) begin
      if (min_d == 6'd0 && sec_d == 6'd0) chime_cnt_d = CHIME_LOAD;
      else if (chime_cnt_q != 4'd0)        chime_cnt_d = chime_cnt_q - 4'd1;
    end
  end

  // Alarm FSM. One counter serves both ring timeout and snooze interval.
  // Dismiss and loss of the slot's arm bit outrank snooze and timeouts.
  always_comb begin
    state_d   = state_q;
    alm_cnt_d = alm_cnt_q;
    ring_id_d = ring_id_q;
    case (state_q)
      ST_IDLE: begin
        if (adv && match_any) begin
          state_d   = ST_RING;
          ring_id_d = match_idx;
          alm_cnt_d = RING_LOAD;
        end
      end
      ST_RING: begin
        if (dismiss || !en_sel) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          alm_cnt_d = SNOOZE_LOAD;
        end else if (adv) begin
          alm_cnt_d = alm_cnt_q - 10'd1;
          if (alm_cnt_q == 10'd1) state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (dismiss || !en_sel) begin
          state_d = ST_IDLE;
        end else if (adv) begin
          if (alm_cnt_q == 10'd1) begin
            state_d   = ST_RING;
            alm_cnt_d = RING_LOAD;
          end else begin
            alm_cnt_d = alm_cnt_q - 10'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q     <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      alm_hour_q  <= '0;
      alm_min_q   <= '0;
      alm_sec_q   <= '0;
      chime_cnt_q <= '0;
      alm_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      ring_id_q   <= '0;
      sec_pulse_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alm_hour_q  <= alm_hour_d;
      alm_min_q   <= alm_min_d;
      alm_sec_q   <= alm_sec_d;
      chime_cnt_q <= chime_cnt_d;
      alm_cnt_q   <= alm_cnt_d;
      state_q     <= state_d;
      ring_id_q   <= ring_id_d;
      sec_pulse_q <= adv;
      wr_err_q    <= wr_en && !wr_ok;
    end
  end

  // 12-hour view: 0 shows as 12, 13..23 fold down by 12.
  always_comb begin
    if (!mode_12h)           disp_hour = hour_q;
    else if (hour_q == 5'd0) disp_hour = 5'd12;
    else if (hour_q > 5'd12) disp_hour = hour_q - 5'd12;
    else                     disp_hour = hour_q;
    pm = mode_12h && (hour_q >= 5'd12);
  end

  assign hour      = hour_q;
  assign minute    = min_q;
  assign second    = sec_q;
  assign sec_pulse = sec_pulse_q;
  assign chime     = (chime_cnt_q != 4'd0);
  assign ringing   = (state_q == ST_RING);
  assign snoozed   = (state_q == ST_SNOOZE);
  assign ring_id   = ring_id_q;
  assign wr_err    = wr_err_q;

endmodule
